draw_arbiter: RTL and testbench

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_draw_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : draw_arbiter
// Brief   : Round-robin arbiter for four sprite requesters sharing one pixel
//           port; the winner's square sprite is rasterised row-major.
// Rev     : 1.0
// ============================================================================
module draw_arbiter #(
    parameter int SPRITE_SIZE = 8
) (
    input  logic        CLOCK_50,
    input  logic        Reset,
    input  logic [3:0]  Req,
    input  logic [31:0] BaseX,
    input  logic [27:0] BaseY,
    input  logic [11:0] Colour,
    output logic [3:0]  Grant,
    output logic [3:0]  Done,
    output logic [7:0]  VGA_X,
    output logic [6:0]  VGA_Y,
    output logic [2:0]  VGA_Colour,
    output logic        Plot,
    output logic        Busy
);

    localparam int              CW        = $clog2(SPRITE_SIZE);
    localparam logic [CW-1:0]   C_LAST    = CW'(SPRITE_SIZE - 1);
    localparam logic [8:0]      C_X_LIMIT = 9'd160;
    localparam logic [7:0]      C_Y_LIMIT = 8'd120;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    ptr_q,   ptr_d;
    logic [1:0]    gidx_q,  gidx_d;
    logic [3:0]    grant_q, grant_d;
    logic [3:0]    done_q,  done_d;
    logic [CW-1:0] cx_q,    cx_d;
    logic [CW-1:0] cy_q,    cy_d;
    logic [7:0]    bx_q,    bx_d;
    logic [6:0]    by_q,    by_d;
    logic [2:0]    col_q,   col_d;
    logic [7:0]    vx_q,    vx_d;
    logic [6:0]    vy_q,    vy_d;
    logic          plot_q,  plot_d;

    // ------------------------------------------------------------------
    // Round-robin selection: lowest offset from ptr wins
    // ------------------------------------------------------------------
    logic [1:0] sel_idx;
    logic       sel_valid;

    always_comb begin
        logic [1:0] cand;
        sel_idx   = ptr_q;
        sel_valid = 1'b0;
        cand      = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (Req[cand]) begin
                sel_idx   = cand;
                sel_valid = 1'b1;
            end
        end
    end

    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_col;

    always_comb begin
        sel_x   = BaseX[int'(sel_idx) * 8 +: 8];
        sel_y   = BaseY[int'(sel_idx) * 7 +: 7];
        sel_col = Colour[int'(sel_idx) * 3 +: 3];
    end

    // ------------------------------------------------------------------
    // Next pixel in row-major order and its unclipped screen position
    // ------------------------------------------------------------------
    logic          last_px;
    logic          row_end;
    logic [CW-1:0] nx_cx;
    logic [CW-1:0] nx_cy;
    logic [8:0]    sum_x;
    logic [7:0]    sum_y;
    logic          sel_in_bounds;

    always_comb begin
        row_end       = (cx_q == C_LAST);
        last_px       = row_end && (cy_q == C_LAST);
        nx_cx         = row_end ? '0 : cx_q + CW'(1);
        nx_cy         = row_end ? cy_q + CW'(1) : cy_q;
        sum_x         = {1'b0, bx_q} + 9'(nx_cx);
        sum_y         = {1'b0, by_q} + 8'(nx_cy);
        sel_in_bounds = ({1'b0, sel_x} < C_X_LIMIT) && ({1'b0, sel_y} < C_Y_LIMIT);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sel_valid) state_d = S_DRAW;
            S_DRAW:  if (last_px)   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values (all outputs are registered)
    // ------------------------------------------------------------------
    always_comb begin
        grant_d = grant_q;
        done_d  = 4'b0000;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        bx_d    = bx_q;
        by_d    = by_q;
        col_d   = col_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        plot_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_valid) begin
                    gidx_d  = sel_idx;
                    grant_d = 4'b0001 << sel_idx;
                    cx_d    = '0;
                    cy_d    = '0;
                    bx_d    = sel_x;
                    by_d    = sel_y;
                    col_d   = sel_col;
                    vx_d    = sel_x;
                    vy_d    = sel_y;
                    plot_d  = sel_in_bounds;
                end
            end
            S_DRAW: begin
                // Off-screen pixels still consume a cycle; only the strobe drops.
                if (!last_px) begin
                    cx_d   = nx_cx;
                    cy_d   = nx_cy;
                    vx_d   = sum_x[7:0];
                    vy_d   = sum_y[6:0];
                    plot_d = (sum_x < C_X_LIMIT) && (sum_y < C_Y_LIMIT);
                end
            end
            S_DONE: begin
                done_d  = grant_q;
                grant_d = 4'b0000;
                ptr_d   = gidx_q + 2'd1;
            end
            default: begin
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            ptr_q   <= 2'd0;
            gidx_q  <= 2'd0;
            grant_q <= 4'b0000;
            done_q  <= 4'b0000;
            cx_q    <= '0;
            cy_q    <= '0;
            bx_q    <= 8'd0;
            by_q    <= 7'd0;
            col_q   <= 3'd0;
            vx_q    <= 8'd0;
            vy_q    <= 7'd0;
            plot_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            col_q   <= col_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            plot_q  <= plot_d;
        end
    end

    // Latched colour only changes on a grant, so it doubles as the held output.
    assign Grant      = grant_q;
    assign Done       = done_q;
    assign VGA_X      = vx_q;
    assign VGA_Y      = vy_q;
    assign VGA_Colour = col_q;
    assign Plot       = plot_q;
    assign Busy       = (state_q == S_DRAW) || (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_draw_arbiter
// Brief   : Self-checking bench for draw_arbiter with a job-timeline model.
// Rev     : 1.0
// ============================================================================
module tb_draw_arbiter;

    localparam int S = 8;
    localparam int N = S * S;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] bx;
    logic [27:0] by;
    logic [11:0] col;
    logic [3:0]  Grant, Done;
    logic [7:0]  VGA_X;
    logic [6:0]  VGA_Y;
    logic [2:0]  VGA_Colour;
    logic        Plot, Busy;

    always #5 clk = ~clk;

    draw_arbiter #(.SPRITE_SIZE(S)) dut (
        .CLOCK_50   (clk),
        .Reset      (rst),
        .Req        (req),
        .BaseX      (bx),
        .BaseY      (by),
        .Colour     (col),
        .Grant      (Grant),
        .Done       (Done),
        .VGA_X      (VGA_X),
        .VGA_Y      (VGA_Y),
        .VGA_Colour (VGA_Colour),
        .Plot       (Plot),
        .Busy       (Busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: a job is a timeline of age 1..N pixels, N+1 wrap-up,
    // followed by the completion pulse on the first idle cycle.
    // ------------------------------------------------------------------
    int   age = 0, m_g = 0, m_ptr = 0, m_c = 0;
    int   m_bx = 0, m_by = 0, m_col = 0, m_p = 0, m_x = 0, m_y = 0;
    int   last_x = 0, last_y = 0, last_col = 0;
    logic [3:0] e_grant = 0, e_done = 0;
    logic       e_plot = 0, e_busy = 0;
    bit         started = 0;

    always @(posedge clk) begin
        started = 1;
        e_done  = 4'b0000;
        if (rst) begin
            age = 0; m_ptr = 0; m_g = 0;
            last_x = 0; last_y = 0; last_col = 0;
        end else if (age == 0) begin
            for (int k = 0; k < 4; k++) begin
                m_c = (m_ptr + k) % 4;
                if (req[m_c]) begin
                    m_g   = m_c;
                    m_bx  = int'((bx >> (8 * m_c)) & 32'hFF);
                    m_by  = int'((by >> (7 * m_c)) & 28'h7F);
                    m_col = int'((col >> (3 * m_c)) & 12'h7);
                    age   = 1;
                    break;
                end
            end
        end else if (age <= N) begin
            age++;
        end else begin
            e_done = 4'(1 << m_g);
            m_ptr  = (m_g + 1) % 4;
            age    = 0;
        end
        e_plot = 1'b0;
        if (age >= 1 && age <= N) begin
            m_p      = age - 1;
            m_x      = m_bx + m_p % S;
            m_y      = m_by + m_p / S;
            e_plot   = (m_x < 160) && (m_y < 120);
            last_x   = m_x % 256;
            last_y   = m_y % 128;
            last_col = m_col;
        end
        e_grant = (age > 0) ? 4'(1 << m_g) : 4'b0000;
        e_busy  = (age > 0);
    end

    always @(negedge clk) begin
        if (started) begin
            chk("grant",  32'(Grant),      32'(e_grant));
            chk("done",   32'(Done),       32'(e_done));
            chk("plot",   32'(Plot),       32'(e_plot));
            chk("busy",   32'(Busy),       32'(e_busy));
            chk("vga_x",  32'(VGA_X),      32'(last_x));
            chk("vga_y",  32'(VGA_Y),      32'(last_y));
            chk("colour", 32'(VGA_Colour), 32'(last_col));
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (inputs driven on the falling edge)
    // ------------------------------------------------------------------
    int         w_plots, w_done_at, w_fx, w_fy, w_lx, w_ly;
    logic [3:0] w_done_v, w_g1;
    logic [3:0] g_seq[8];
    int         g_cyc[8];
    int         g_n;

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic watch(input int ncyc, input int drop_at);
        w_plots = 0; w_done_at = 0; w_done_v = 0; w_g1 = 0;
        w_fx = 0; w_fy = 0; w_lx = 0; w_ly = 0;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (i == 1) begin w_g1 = Grant; w_fx = VGA_X; w_fy = VGA_Y; end
            if (i == N) begin w_lx = VGA_X; w_ly = VGA_Y; end
            if (Plot) w_plots++;
            if (Done != 0 && w_done_at == 0) begin w_done_at = i; w_done_v = Done; end
            if (i == drop_at) req = 4'b0000;
        end
    endtask

    task automatic record_grants(input int ncyc);
        logic [3:0] prev;
        prev = 4'b0000;
        g_n  = 0;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (Grant != 0 && Grant != prev && g_n < 8) begin
                g_seq[g_n] = Grant; g_cyc[g_n] = i; g_n++;
            end
            prev = Grant;
        end
    endtask

    initial begin
        rst = 1'b1; req = 0; bx = 0; by = 0; col = 0;
        do_reset();

        // Single request from requester 1
        bx = 32'd10 << 8; by = 28'd20 << 7; col = 12'b100 << 3; req = 4'b0010;
        watch(70, 1);
        chk("s1_grant",   32'(w_g1), 32'h2);
        chk("s1_plots",   w_plots,   64);
        chk("s1_first_x", w_fx, 10);
        chk("s1_first_y", w_fy, 20);
        chk("s1_last_x",  w_lx, 17);
        chk("s1_last_y",  w_ly, 27);
        chk("s1_done_at", w_done_at, 66);
        chk("s1_done",    32'(w_done_v), 32'h2);

        // Pointer now at 2
        req = 4'b1111;
        watch(70, 1);
        chk("ptr2_grant", 32'(w_g1), 32'h4);

        // Full contention from reset
        do_reset();
        req = 4'b1111;
        record_grants(270);
        chk("cont_n", g_n, 5);
        chk("cont_g0", 32'(g_seq[0]), 32'h1);
        chk("cont_g1", 32'(g_seq[1]), 32'h2);
        chk("cont_g2", 32'(g_seq[2]), 32'h4);
        chk("cont_g3", 32'(g_seq[3]), 32'h8);
        chk("cont_g4", 32'(g_seq[4]), 32'h1);
        for (int i = 1; i < 5; i++) chk("cont_gap", g_cyc[i] - g_cyc[i-1], 66);

        // Re-request fairness
        do_reset();
        req = 4'b0011;
        record_grants(70);
        chk("fair_g0", 32'(g_seq[0]), 32'h1);
        chk("fair_g1", 32'(g_seq[1]), 32'h2);

        // Clipping at the bottom-right corner
        do_reset();
        bx = 32'd156; by = 28'd116; col = 12'h5; req = 4'b0001;
        watch(70, 1);
        chk("clip_plots",   w_plots, 16);
        chk("clip_done_at", w_done_at, 66);

        // Request dropped mid-sprite
        bx = 32'd40 << 24; by = 28'd40 << 21; req = 4'b1000;
        watch(70, 5);
        chk("drop_plots", w_plots, 64);
        chk("drop_done",  32'(w_done_v), 32'h8);

        // Reset mid-draw
        do_reset();
        bx = 32'd20 << 16; by = 28'd20 << 14; col = 12'h7 << 6; req = 4'b0100;
        watch(31, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_grant", 32'(Grant), 32'h0);
        chk("rst_plot",  32'(Plot),  32'h0);
        chk("rst_x",     32'(VGA_X), 32'h0);
        chk("rst_busy",  32'(Busy),  32'h0);
        rst = 1'b0; req = 4'b0101;
        watch(70, 1);
        chk("rst_regrant", 32'(w_g1), 32'h1);
        chk("rst_done",    32'(w_done_v), 32'h1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            bx  = $urandom;
            by  = 28'($urandom);
            col = 12'($urandom);
        end
        rst = 1'b0; req = 4'b0000;
        repeat (80) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
